// File: rtl/seri_verici.sv
// Bit-serial transmitter: accepts a parallel word on baslat & hazir and sends it
// MSB-first on cikis_bit, each bit held BIT_CYCLES clocks, followed by a bitti pulse.
module seri_verici #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             saat,
  input  logic             reset,
  input  logic [WIDTH-1:0] veri,
  input  logic             baslat,
  output logic             hazir,
  output logic             cikis_bit,
  output logic             gecerli,
  output logic             bitti
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_SON = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_SON = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOS    = 2'b00,
    GONDER = 2'b01,
    BITIR  = 2'b10
  } durum_t;

  durum_t           durum, durum_sonraki;
  logic [WIDTH-1:0] kaydirma;
  logic [BW-1:0]    bit_sayac;
  logic [CW-1:0]    cyc_sayac;
  logic             kabul;
  logic             bit_sonu;

  assign kabul    = (durum == BOS) && baslat;
  assign bit_sonu = (durum == GONDER) && (cyc_sayac == CYC_SON);

  always_ff @(posedge saat) begin
    if (reset) durum <= BOS;
    else       durum <= durum_sonraki;
  end

  // Outputs decode only the registered state; baslat only steers the next state.
  always_comb begin
    durum_sonraki = BOS;
    hazir         = 1'b0;
    cikis_bit     = 1'b1;
    gecerli       = 1'b0;
    bitti         = 1'b0;
    case (durum)
      BOS: begin
        hazir         = 1'b1;
        durum_sonraki = baslat ? GONDER : BOS;
      end
      GONDER: begin
        cikis_bit     = kaydirma[WIDTH-1];
        gecerli       = (cyc_sayac == '0);
        durum_sonraki = (bit_sonu && (bit_sayac == BIT_SON)) ? BITIR : GONDER;
      end
      BITIR: begin
        bitti         = 1'b1;
        durum_sonraki = BOS;
      end
      default: durum_sonraki = BOS;
    endcase
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      kaydirma  <= '0;
      bit_sayac <= '0;
      cyc_sayac <= '0;
    end else if (kabul) begin
      kaydirma  <= veri;
      bit_sayac <= '0;
      cyc_sayac <= '0;
    end else if (durum == GONDER) begin
      if (bit_sonu) begin
        cyc_sayac <= '0;
        kaydirma  <= kaydirma << 1;
        bit_sayac <= bit_sayac + 1'b1;
      end else begin
        cyc_sayac <= cyc_sayac + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seri_verici.sv
// Bench for seri_verici: two instances (8x4 and 4x1) checked every cycle against a
// frame-level model, plus directed frames with hand-computed expectations.
module tb_seri_verici;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, baslat_a, hazir_a, bit_a, gec_a, bitti_a;
  logic [7:0] veri_a;
  logic       reset_b, baslat_b, hazir_b, bit_b, gec_b, bitti_b;
  logic [3:0] veri_b;

  seri_verici #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .saat(clk), .reset(reset_a), .veri(veri_a), .baslat(baslat_a),
    .hazir(hazir_a), .cikis_bit(bit_a), .gecerli(gec_a), .bitti(bitti_a)
  );

  seri_verici #(.WIDTH(4), .BIT_CYCLES(1)) dut_b (
    .saat(clk), .reset(reset_b), .veri(veri_b), .baslat(baslat_b),
    .hazir(hazir_b), .cikis_bit(bit_b), .gecerli(gec_b), .bitti(bitti_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected {hazir, cikis_bit, gecerli, bitti} k cycles after a frame was accepted.
  function automatic logic [3:0] model_out(input bit busy, input int k, input logic [7:0] word,
                                           input int w, input int bc);
    if (!busy) return 4'b1100;
    if (k < w * bc) return {1'b0, word[w - 1 - k / bc], (k % bc == 0), 1'b0};
    return 4'b0101;
  endfunction

  bit         busy_a = 0, en_a = 0, busy_b = 0, en_b = 0;
  int         k_a = 0, k_b = 0;
  logic [7:0] word_a = '0, word_b = '0;

  always @(posedge clk) begin
    if (reset_a) begin
      busy_a <= 0;
      en_a   <= 1;
    end else if (!busy_a) begin
      if (baslat_a) begin
        busy_a <= 1;
        k_a    <= 0;
        word_a <= veri_a;
      end
    end else if (k_a >= 8 * 4) busy_a <= 0;
    else k_a <= k_a + 1;

    if (reset_b) begin
      busy_b <= 0;
      en_b   <= 1;
    end else if (!busy_b) begin
      if (baslat_b) begin
        busy_b <= 1;
        k_b    <= 0;
        word_b <= {4'b0, veri_b};
      end
    end else if (k_b >= 4 * 1) busy_b <= 0;
    else k_b <= k_b + 1;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (en_a) begin
      e = model_out(busy_a, k_a, word_a, 8, 4);
      check("a_hazir", hazir_a, e[3]);
      check("a_cikis_bit", bit_a, e[2]);
      check("a_gecerli", gec_a, e[1]);
      check("a_bitti", bitti_a, e[0]);
    end
    if (en_b) begin
      e = model_out(busy_b, k_b, word_b, 4, 1);
      check("b_hazir", hazir_b, e[3]);
      check("b_cikis_bit", bit_b, e[2]);
      check("b_gecerli", gec_b, e[1]);
      check("b_bitti", bitti_b, e[0]);
    end
  end

  task automatic cap_a(input logic [7:0] v, output logic [7:0] bits,
                       output int nb, output int nh, output int ng);
    bits = '0; nb = -1; nh = -1; ng = 0;
    @(negedge clk); veri_a = v; baslat_a = 1;
    @(negedge clk); baslat_a = 0;
    for (int n = 0; n < 60; n++) begin
      if (n < 32 && n % 4 == 0) bits[7 - n / 4] = bit_a;
      if (gec_a) ng++;
      if (bitti_a && nb < 0) nb = n;
      if (hazir_a && nh < 0) nh = n;
      if (nh >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic cap_b(input logic [3:0] v, output logic [3:0] bits,
                       output int nb, output int nh, output int ng);
    bits = '0; nb = -1; nh = -1; ng = 0;
    @(negedge clk); veri_b = v; baslat_b = 1;
    @(negedge clk); baslat_b = 0;
    for (int n = 0; n < 20; n++) begin
      if (n < 4) bits[3 - n] = bit_b;
      if (gec_b) ng++;
      if (bitti_b && nb < 0) nb = n;
      if (hazir_b && nh < 0) nh = n;
      if (nh >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(hazir_a && hazir_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, (n < 100), 1);
  endtask

  initial begin
    logic [7:0] bits8;
    logic [3:0] bits4;
    int nb, nh, ng, cnt;

    // Reset held two clocks with baslat asserted: nothing may start.
    reset_a = 1; baslat_a = 1; veri_a = 8'hA5;
    reset_b = 1; baslat_b = 1; veri_b = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_hazir_a", hazir_a, 1);
    check("rst_bit_a", bit_a, 1);
    check("rst_gec_a", gec_a, 0);
    check("rst_bitti_a", bitti_a, 0);
    check("rst_hazir_b", hazir_b, 1);
    reset_a = 0; baslat_a = 0; reset_b = 0; baslat_b = 0;

    check("model_idle", model_out(0, 0, 8'hA5, 8, 4), 4'b1100);
    check("model_k4", model_out(1, 4, 8'hA5, 8, 4), 4'b0010);
    check("model_k5", model_out(1, 5, 8'hA5, 8, 4), 4'b0000);
    check("model_k28", model_out(1, 28, 8'hA5, 8, 4), 4'b0110);
    check("model_end", model_out(1, 32, 8'hA5, 8, 4), 4'b0101);

    // Single A5 frame.
    cap_a(8'hA5, bits8, nb, nh, ng);
    check("a5_bits", bits8, 8'hA5);
    check("a5_bitti_at", nb, 32);
    check("a5_hazir_at", nh, 33);
    check("a5_gec_count", ng, 8);

    // baslat held high, veri changed mid-frame.
    @(negedge clk); veri_a = 8'h3C; baslat_a = 1;
    @(negedge clk);
    bits8 = '0; nb = -1;
    for (int n = 0; n < 60; n++) begin
      if (n == 10) veri_a = 8'hFF;
      if (n < 32 && n % 4 == 0) bits8[7 - n / 4] = bit_a;
      if (bitti_a) begin nb = n; break; end
      @(negedge clk);
    end
    check("b2b_frame1", bits8, 8'h3C);
    check("b2b_bitti_at", nb, 32);
    @(negedge clk);
    check("b2b_bos_hazir", hazir_a, 1);
    @(negedge clk);
    check("b2b_frame2_hazir", hazir_a, 0);
    check("b2b_frame2_bit", bit_a, 1);
    check("b2b_frame2_gec", gec_a, 1);
    baslat_a = 0;
    wait_idle("b2b");

    // Reset during the third bit of F0, then a clean 01 frame.
    @(negedge clk); veri_a = 8'hF0; baslat_a = 1;
    @(negedge clk); baslat_a = 0;
    repeat (9) @(negedge clk);
    reset_a = 1;
    @(negedge clk); reset_a = 0;
    check("abort_hazir", hazir_a, 1);
    check("abort_bit", bit_a, 1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bitti_a) cnt++;
    end
    check("abort_no_bitti", cnt, 0);
    cap_a(8'h01, bits8, nb, nh, ng);
    check("after_abort_bits", bits8, 8'h01);
    check("after_abort_bitti_at", nb, 32);

    // 4-bit, one clock per bit.
    cap_b(4'b1001, bits4, nb, nh, ng);
    check("w4_bits", bits4, 4'b1001);
    check("w4_bitti_at", nb, 4);
    check("w4_hazir_at", nh, 5);
    check("w4_gec_count", ng, 4);

    // baslat pulses in GONDER and BITIR are dropped.
    @(negedge clk); veri_a = 8'h96; baslat_a = 1;
    @(negedge clk); baslat_a = 0;
    cnt = 0;
    for (int n = 0; n < 80; n++) begin
      baslat_a = (n == 5) || (bitti_a === 1'b1);
      if (bitti_a) cnt++;
      @(negedge clk);
    end
    baslat_a = 0;
    check("ignore_frames", cnt, 1);
    check("ignore_idle", hazir_a, 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      baslat_a = ($urandom_range(0, 3) == 0);
      veri_a   = 8'($urandom);
      reset_a  = ($urandom_range(0, 299) == 0);
      baslat_b = ($urandom_range(0, 1) == 0);
      veri_b   = 4'($urandom);
      reset_b  = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    baslat_a = 0; baslat_b = 0; reset_a = 0; reset_b = 0;
    wait_idle("final");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
